// File: rtl/mgmt_phy_controller_if.sv
// Status/control bundle between the LTPI frame datapath, PLL reconfig
// controller and the Controller-side PHY management FSM.
interface mgmt_phy_controller_if;
    logic [3:0] tx_frm_offset;
    logic       aligned;
    logic       frame_crc_err;
    logic       crc_consec_loss;
    logic       unexpected_frame_error;
    logic       operational_frm_lost_error;
    logic       remote_software_reset;
    logic       link_detect_locked;
    logic       transmited_255_detect_frm;
    logic       link_speed_locked;
    logic       link_speed_timeout_detect;
    logic       advertise_locked;
    logic       accept_frm_recv;
    logic       pll_configuration_done;
    logic       change_freq_st;
    logic       pll_reconfig;
    logic       send_configure;
    logic       link_lost_pulse;
    logic [3:0] cfg_retry_cnt;

    // The FSM side: consumes datapath status, drives PLL/TX controls.
    modport master (
        input  tx_frm_offset, aligned, frame_crc_err, crc_consec_loss,
               unexpected_frame_error, operational_frm_lost_error,
               remote_software_reset, link_detect_locked,
               transmited_255_detect_frm, link_speed_locked,
               link_speed_timeout_detect, advertise_locked, accept_frm_recv,
               pll_configuration_done, change_freq_st,
        output pll_reconfig, send_configure, link_lost_pulse, cfg_retry_cnt
    );

    modport slave (
        output tx_frm_offset, aligned, frame_crc_err, crc_consec_loss,
               unexpected_frame_error, operational_frm_lost_error,
               remote_software_reset, link_detect_locked,
               transmited_255_detect_frm, link_speed_locked,
               link_speed_timeout_detect, advertise_locked, accept_frm_recv,
               pll_configuration_done, change_freq_st,
        input  pll_reconfig, send_configure, link_lost_pulse, cfg_retry_cnt
    );
endinterface

// File: rtl/mgmt_phy_controller.sv
// LTPI Controller-side link-training / PHY management FSM:
// Detect -> Speed -> PLL change -> Advertise -> Configure -> Operational.
package ltpi_pkg;
    typedef logic [3:0] rstate_t;

    localparam rstate_t ST_INIT                       = 4'd0;
    localparam rstate_t ST_COMMA_HUNTING              = 4'd1;
    localparam rstate_t ST_WAIT_LINK_DETECT_LOCKED    = 4'd2;
    localparam rstate_t ST_WAIT_LINK_SPEED_LOCKED     = 4'd3;
    localparam rstate_t ST_LINK_SPEED_CHANGE          = 4'd4;
    localparam rstate_t ST_WAIT_LINK_ADVERTISE_LOCKED = 4'd5;
    localparam rstate_t ST_WAIT_IN_ADVERTISE          = 4'd6;
    localparam rstate_t ST_CONFIGURATION_OR_ACCEPT    = 4'd7;
    localparam rstate_t ST_OPERATIONAL                = 4'd8;
    localparam rstate_t ST_OPERATIONAL_RESET          = 4'd9;
    localparam rstate_t ST_LINK_LOST_ERR              = 4'd10;

    typedef struct packed {
        logic software_reset;
        logic auto_move_config;
        logic trigger_config_st;
    } LTPI_CSR_In_t;
endpackage

module mgmt_phy_controller
    import ltpi_pkg::*;
#(
    parameter int unsigned TIMER_1MS_CYCLES = 60000,
    parameter logic [3:0]  FRAME_LENGTH     = 4'd15,
    parameter int unsigned CFG_RETRY_MAX    = 3
) (
    input  logic                         clk,
    input  logic                         reset_n,
    mgmt_phy_controller_if.master        phy,
    input  LTPI_CSR_In_t                 LTPI_CSR_In,
    output rstate_t                      LTPI_link_ST
);

    localparam int unsigned T1_MAX   = TIMER_1MS_CYCLES - 1;
    localparam int unsigned T100_MAX = 100 * TIMER_1MS_CYCLES - 1;
    localparam int unsigned T1_W     = ($clog2(TIMER_1MS_CYCLES) > 0) ? $clog2(TIMER_1MS_CYCLES) : 1;
    localparam int unsigned T100_W   = $clog2(100 * TIMER_1MS_CYCLES);

    rstate_t           rstate_q, rstate_d;
    rstate_t           link_st_q, link_st_d;
    logic [3:0]        cfg_retry_cnt_q, cfg_retry_cnt_d;
    logic              pll_reconfig_q, pll_reconfig_d;
    logic              send_configure_q, send_configure_d;
    logic              link_lost_pulse_q, link_lost_pulse_d;
    logic [T1_W-1:0]   t1_q, t1_d;
    logic [T100_W-1:0] t100_q, t100_d;

    logic       link_lost;
    logic       bnd;
    logic       t1_done;
    logic       t100_done;
    logic       state_change;
    logic [3:0] cfg_retry_inc;

    assign link_lost     = phy.crc_consec_loss | (phy.unexpected_frame_error & ~phy.frame_crc_err);
    assign bnd           = (phy.tx_frm_offset == FRAME_LENGTH);
    assign t1_done       = (t1_q == T1_W'(T1_MAX));
    assign t100_done     = (t100_q == T100_W'(T100_MAX));
    assign cfg_retry_inc = cfg_retry_cnt_q + 4'd1;

    always_comb begin
        rstate_d        = rstate_q;
        cfg_retry_cnt_d = cfg_retry_cnt_q;
        case (rstate_q)
            ST_INIT: begin
                cfg_retry_cnt_d = '0;
                if (phy.pll_configuration_done) rstate_d = ST_COMMA_HUNTING;
            end
            ST_COMMA_HUNTING: begin
                if (phy.aligned && !phy.change_freq_st)     rstate_d = ST_WAIT_LINK_DETECT_LOCKED;
                else if (phy.aligned && phy.change_freq_st) rstate_d = ST_WAIT_LINK_ADVERTISE_LOCKED;
                else if (t100_done)                         rstate_d = ST_LINK_LOST_ERR;
            end
            ST_WAIT_LINK_DETECT_LOCKED: begin
                if (link_lost)
                    rstate_d = ST_LINK_LOST_ERR;
                else if (phy.link_detect_locked && phy.transmited_255_detect_frm && bnd)
                    rstate_d = ST_WAIT_LINK_SPEED_LOCKED;
            end
            ST_WAIT_LINK_SPEED_LOCKED: begin
                if (link_lost || phy.link_speed_timeout_detect) rstate_d = ST_LINK_LOST_ERR;
                else if (phy.link_speed_locked && bnd)          rstate_d = ST_LINK_SPEED_CHANGE;
            end
            ST_LINK_SPEED_CHANGE: begin
                if (phy.pll_configuration_done) rstate_d = ST_COMMA_HUNTING;
            end
            ST_WAIT_LINK_ADVERTISE_LOCKED: begin
                // Once the 1 ms window expires with Advertise locked, the
                // held timer keeps us parked until the next frame boundary.
                if (link_lost) begin
                    rstate_d = ST_LINK_LOST_ERR;
                end else if (t1_done) begin
                    if (!phy.advertise_locked)              rstate_d = ST_LINK_LOST_ERR;
                    else if (!LTPI_CSR_In.auto_move_config) rstate_d = ST_WAIT_IN_ADVERTISE;
                    else if (bnd)                           rstate_d = ST_CONFIGURATION_OR_ACCEPT;
                end
            end
            ST_WAIT_IN_ADVERTISE: begin
                if (link_lost)                                rstate_d = ST_LINK_LOST_ERR;
                else if (LTPI_CSR_In.trigger_config_st && bnd) rstate_d = ST_CONFIGURATION_OR_ACCEPT;
            end
            ST_CONFIGURATION_OR_ACCEPT: begin
                if (link_lost) begin
                    rstate_d = ST_LINK_LOST_ERR;
                end else if (phy.accept_frm_recv && bnd) begin
                    rstate_d        = ST_OPERATIONAL;
                    cfg_retry_cnt_d = '0;
                end else if (t1_done && bnd) begin
                    cfg_retry_cnt_d = cfg_retry_inc;
                    rstate_d = (cfg_retry_inc == 4'(CFG_RETRY_MAX)) ? ST_LINK_LOST_ERR
                                                                     : ST_WAIT_LINK_ADVERTISE_LOCKED;
                end
            end
            ST_OPERATIONAL: begin
                if (link_lost)
                    rstate_d = ST_LINK_LOST_ERR;
                else if (LTPI_CSR_In.software_reset || phy.remote_software_reset)
                    rstate_d = ST_OPERATIONAL_RESET;
                else if (phy.operational_frm_lost_error)
                    rstate_d = ST_LINK_LOST_ERR;
            end
            ST_OPERATIONAL_RESET: begin
                if (bnd) rstate_d = ST_WAIT_LINK_ADVERTISE_LOCKED;
            end
            ST_LINK_LOST_ERR: rstate_d = ST_INIT;
            default:          rstate_d = ST_INIT;
        endcase
    end

    always_comb begin
        state_change      = (rstate_d != rstate_q);
        link_st_d         = rstate_q;
        pll_reconfig_d    = (rstate_d == ST_INIT) || (rstate_d == ST_LINK_SPEED_CHANGE);
        send_configure_d  = (rstate_q == ST_CONFIGURATION_OR_ACCEPT);
        link_lost_pulse_d = (rstate_d == ST_LINK_LOST_ERR);

        t1_d = t1_q;
        if (state_change)
            t1_d = '0;
        else if (((rstate_q == ST_WAIT_LINK_ADVERTISE_LOCKED) ||
                  (rstate_q == ST_CONFIGURATION_OR_ACCEPT)) && !t1_done)
            t1_d = t1_q + T1_W'(1);

        t100_d = t100_q;
        if (state_change)
            t100_d = '0;
        else if ((rstate_q == ST_COMMA_HUNTING) && phy.change_freq_st && !t100_done)
            t100_d = t100_q + T100_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rstate_q          <= ST_INIT;
            link_st_q         <= ST_INIT;
            cfg_retry_cnt_q   <= '0;
            pll_reconfig_q    <= 1'b0;
            send_configure_q  <= 1'b0;
            link_lost_pulse_q <= 1'b0;
            t1_q              <= '0;
            t100_q            <= '0;
        end else begin
            rstate_q          <= rstate_d;
            link_st_q         <= link_st_d;
            cfg_retry_cnt_q   <= cfg_retry_cnt_d;
            pll_reconfig_q    <= pll_reconfig_d;
            send_configure_q  <= send_configure_d;
            link_lost_pulse_q <= link_lost_pulse_d;
            t1_q              <= t1_d;
            t100_q            <= t100_d;
        end
    end

    assign phy.pll_reconfig    = pll_reconfig_q;
    assign phy.send_configure  = send_configure_q;
    assign phy.link_lost_pulse = link_lost_pulse_q;
    assign phy.cfg_retry_cnt   = cfg_retry_cnt_q;
    assign LTPI_link_ST        = link_st_q;

endmodule

// File: tb/tb_mgmt_phy_controller.sv
// Directed bench for mgmt_phy_controller; inputs change and outputs are
// sampled on the falling clock edge.
module tb_mgmt_phy_controller;
    import ltpi_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    LTPI_CSR_In_t csr;
    rstate_t      link_st;
    int           compared   = 0;
    int           mismatched = 0;

    mgmt_phy_controller_if phy_if ();

    mgmt_phy_controller #(
        .TIMER_1MS_CYCLES (8),
        .FRAME_LENGTH     (4'd15),
        .CFG_RETRY_MAX    (3)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .phy          (phy_if),
        .LTPI_CSR_In  (csr),
        .LTPI_link_ST (link_st)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        csr     = '0;
        phy_if.tx_frm_offset              = 4'd0;
        phy_if.aligned                    = 1'b0;
        phy_if.frame_crc_err              = 1'b0;
        phy_if.crc_consec_loss            = 1'b0;
        phy_if.unexpected_frame_error     = 1'b0;
        phy_if.operational_frm_lost_error = 1'b0;
        phy_if.remote_software_reset      = 1'b0;
        phy_if.link_detect_locked         = 1'b0;
        phy_if.transmited_255_detect_frm  = 1'b0;
        phy_if.link_speed_locked          = 1'b0;
        phy_if.link_speed_timeout_detect  = 1'b0;
        phy_if.advertise_locked           = 1'b0;
        phy_if.accept_frm_recv            = 1'b0;
        phy_if.pll_configuration_done     = 1'b0;
        phy_if.change_freq_st             = 1'b0;

        // Reset state
        cyc(3);
        chk ("rst_state", link_st, ST_INIT);
        chkb("rst_pll", phy_if.pll_reconfig, 1'b0);
        chkb("rst_sendcfg", phy_if.send_configure, 1'b0);
        chkb("rst_pulse", phy_if.link_lost_pulse, 1'b0);
        chk ("rst_retry", phy_if.cfg_retry_cnt, 4'd0);

        // INIT: PLL reconfig held until configuration done
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chkb("init_pll_hi", phy_if.pll_reconfig, 1'b1);
        end
        phy_if.pll_configuration_done = 1'b1;
        cyc(1);
        chkb("init_pll_lo", phy_if.pll_reconfig, 1'b0);
        chk ("init_st_lag", link_st, ST_INIT);
        phy_if.pll_configuration_done = 1'b0;
        cyc(1);
        chk ("comma_st", link_st, ST_COMMA_HUNTING);

        // Low-speed training to the speed change
        phy_if.aligned                   = 1'b1;
        phy_if.link_detect_locked        = 1'b1;
        phy_if.transmited_255_detect_frm = 1'b1;
        cyc(1);
        phy_if.aligned = 1'b0;
        cyc(1);
        chk ("detect_st", link_st, ST_WAIT_LINK_DETECT_LOCKED);
        cyc(3);
        chk ("detect_wait_bnd", link_st, ST_WAIT_LINK_DETECT_LOCKED);
        phy_if.link_speed_locked = 1'b1;
        phy_if.tx_frm_offset     = 4'd15;
        cyc(1);
        phy_if.tx_frm_offset = 4'd0;
        cyc(1);
        chk ("speed_st", link_st, ST_WAIT_LINK_SPEED_LOCKED);
        phy_if.tx_frm_offset = 4'd15;
        cyc(1);
        chkb("speedchg_pll", phy_if.pll_reconfig, 1'b1);
        phy_if.tx_frm_offset = 4'd0;
        cyc(1);
        chk ("speedchg_st", link_st, ST_LINK_SPEED_CHANGE);
        phy_if.pll_configuration_done    = 1'b1;
        phy_if.change_freq_st            = 1'b1;
        phy_if.link_detect_locked        = 1'b0;
        phy_if.transmited_255_detect_frm = 1'b0;
        phy_if.link_speed_locked         = 1'b0;
        cyc(1);
        chkb("speedchg_pll_lo", phy_if.pll_reconfig, 1'b0);
        phy_if.pll_configuration_done = 1'b0;
        cyc(1);
        chk ("comma2_st", link_st, ST_COMMA_HUNTING);

        // Advertise -> Configure -> Operational
        phy_if.aligned          = 1'b1;
        phy_if.advertise_locked = 1'b1;
        csr.auto_move_config    = 1'b1;
        cyc(1);
        phy_if.aligned = 1'b0;
        cyc(8);
        chk ("adv_wait_bnd", link_st, ST_WAIT_LINK_ADVERTISE_LOCKED);
        phy_if.tx_frm_offset = 4'd15;
        cyc(1);
        chkb("cfg_send_entry", phy_if.send_configure, 1'b0);
        phy_if.tx_frm_offset = 4'd0;
        cyc(1);
        chkb("cfg_send_hi", phy_if.send_configure, 1'b1);
        chk ("cfg_st", link_st, ST_CONFIGURATION_OR_ACCEPT);
        phy_if.accept_frm_recv = 1'b1;
        phy_if.tx_frm_offset   = 4'd15;
        cyc(1);
        chkb("cfg_send_lag", phy_if.send_configure, 1'b1);
        phy_if.accept_frm_recv = 1'b0;
        phy_if.tx_frm_offset   = 4'd0;
        cyc(1);
        chkb("op_send_lo", phy_if.send_configure, 1'b0);
        chk ("op_st", link_st, ST_OPERATIONAL);
        chk ("op_retry", phy_if.cfg_retry_cnt, 4'd0);

        // Software reset, then Configure retries exhausted (bnd every cycle)
        csr.software_reset = 1'b1;
        cyc(1);
        csr.software_reset = 1'b0;
        cyc(1);
        chk ("opreset_st", link_st, ST_OPERATIONAL_RESET);
        phy_if.tx_frm_offset = 4'd15;
        cyc(16);
        chk ("retry0", phy_if.cfg_retry_cnt, 4'd0);
        chkb("retry0_send", phy_if.send_configure, 1'b1);
        cyc(1);
        chk ("retry1", phy_if.cfg_retry_cnt, 4'd1);
        cyc(16);
        chk ("retry2", phy_if.cfg_retry_cnt, 4'd2);
        cyc(16);
        chk ("retry3", phy_if.cfg_retry_cnt, 4'd3);
        chkb("retry_pulse", phy_if.link_lost_pulse, 1'b1);
        chk ("retry_st_lag", link_st, ST_CONFIGURATION_OR_ACCEPT);
        cyc(1);
        chkb("retry_pulse_end", phy_if.link_lost_pulse, 1'b0);
        chk ("lost_st", link_st, ST_LINK_LOST_ERR);
        cyc(1);
        chk ("lost_init_st", link_st, ST_INIT);
        chk ("lost_init_retry", phy_if.cfg_retry_cnt, 4'd0);
        chkb("lost_init_pll", phy_if.pll_reconfig, 1'b1);

        // Operational: link loss beats software reset in the same cycle
        phy_if.pll_configuration_done = 1'b1;
        phy_if.aligned                = 1'b1;
        phy_if.accept_frm_recv        = 1'b1;
        cyc(1);
        phy_if.pll_configuration_done = 1'b0;
        cyc(1);
        phy_if.aligned = 1'b0;
        cyc(10);
        chk ("op2_st", link_st, ST_OPERATIONAL);
        phy_if.crc_consec_loss = 1'b1;
        csr.software_reset     = 1'b1;
        cyc(1);
        chkb("prio_pulse", phy_if.link_lost_pulse, 1'b1);
        phy_if.crc_consec_loss = 1'b0;
        csr.software_reset     = 1'b0;
        phy_if.accept_frm_recv = 1'b0;
        cyc(1);
        chk ("prio_lost_st", link_st, ST_LINK_LOST_ERR);

        // 100 ms comma-hunting timeout at operational speed
        phy_if.pll_configuration_done = 1'b1;
        cyc(1);
        phy_if.pll_configuration_done = 1'b0;
        cyc(799);
        chkb("t100_pulse_pre", phy_if.link_lost_pulse, 1'b0);
        chk ("t100_st_pre", link_st, ST_COMMA_HUNTING);
        cyc(1);
        chkb("t100_pulse", phy_if.link_lost_pulse, 1'b1);
        cyc(1);
        chk ("t100_lost_st", link_st, ST_LINK_LOST_ERR);

        // Reset in the middle of Configure
        phy_if.pll_configuration_done = 1'b1;
        phy_if.aligned                = 1'b1;
        cyc(1);
        phy_if.pll_configuration_done = 1'b0;
        cyc(1);
        phy_if.aligned = 1'b0;
        cyc(9);
        chkb("midcfg_send", phy_if.send_configure, 1'b1);
        chk ("midcfg_st", link_st, ST_CONFIGURATION_OR_ACCEPT);
        reset_n = 1'b0;
        cyc(1);
        chk ("midrst_st", link_st, ST_INIT);
        chkb("midrst_send", phy_if.send_configure, 1'b0);
        chkb("midrst_pll", phy_if.pll_reconfig, 1'b0);
        chkb("midrst_pulse", phy_if.link_lost_pulse, 1'b0);
        chk ("midrst_retry", phy_if.cfg_retry_cnt, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
